mul_float_fract_iterative: RTL
==============================

# mul_float_fract_iterative

Iterative significand-multiply stage of the single-precision float multiplier. It accepts unpacked operands (sign, biased exponent, 24-bit significand with hidden bit, exception flags). It produces the sign, the pre-normalisation exponent and the exact 48-bit significand product for the normalize/round-to-even stage directly downstream. The product is built by a shift-add datapath over several cycles, so this block applies real backpressure upstream, while the downstream stage passes its busy straight through.

## Interface
- BITS_PER_CYCLE, 2, multiplier bits retired per step; legal values 1, 2, 4; step count N = 24/BITS_PER_CYCLE.
- iCLOCK  in  1  clock, all flops on rising edge.
- inRESET  in  1  reset, asynchronous, active-low.
- iRESET_SYNC  in  1  synchronous clear, active-high.
- iDATA_VALID  in  1  operand valid.
- oDATA_BUSY  out  1  high when this stage cannot accept an operand.
- iDATA_SIGN_A / iDATA_SIGN_B  in  1 each  operand signs.
- iDATA_EXP_A / iDATA_EXP_B  in  8 each  biased exponents.
- iDATA_FRACT_A / iDATA_FRACT_B  in  24 each  significands, hidden bit at [23].
- iDATA_EXCEPT_EXP_A0, _EXP_B0, _EXP_A1, _EXP_B1, _FRACT_A0, _FRACT_B0  in  1 each  exception flags, carried unchanged.
- oDATA_VALID  out  1  result valid.
- iDATA_BUSY  in  1  downstream busy.
- oDATA_SIGN  out  1  sign of the result.
- oDATA_EXP  out  10  exponent of the result, two's complement.
- oDATA_FRACT  out  48  significand product.
- oDATA_EXCEPT_* (six)  out  1 each  registered copies of the input flags.

## Operation
- States: IDLE, CALC, DONE. oDATA_BUSY = (state != IDLE), decoded combinationally from the state register.
- Accept: in IDLE with iDATA_VALID=1, capture the operands. At the same time:
  - sign register <= iDATA_SIGN_A ^ iDATA_SIGN_B.
  - exp register <= zero-extended A + B − 127, taken mod 2^10.
  - capture the flags.
  - load the multiplicand (FRACT_A) and the multiplier (FRACT_B).
  - clear the product accumulator and the step counter.
  - go to CALC.
- CALC: each cycle retire the low BITS_PER_CYCLE multiplier bits by adding the partial product into the accumulator and shifting right. The carry must be kept; no truncation is allowed.
  - After exactly N steps the 48-bit accumulator equals FRACT_A × FRACT_B exactly.
  - The step counter is ceil(log2(N+1)) bits wide.
  - On the Nth step, go to DONE and set oDATA_VALID=1.
- There is no early termination. Zero or denormal significands still take N steps.
- DONE: hold every output stable while iDATA_BUSY=1. On the first edge with iDATA_BUSY=0, clear oDATA_VALID and go to IDLE.
- iDATA_VALID is ignored outside IDLE. Upstream must hold its data until it sees busy low. Data presented while busy is not captured.
- Data outputs are registers and keep their last values when oDATA_VALID=0. The bench checks them only when valid.
- Priority: inRESET, then iRESET_SYNC, then normal operation. Both resets force IDLE and zero every register, including all outputs. This aborts any CALC or DONE in progress and discards the result.

## Timing
- Reset values: oDATA_VALID=0, oDATA_BUSY=0 (IDLE), oDATA_SIGN=0, oDATA_EXP=10'h000, oDATA_FRACT=48'h0, all oDATA_EXCEPT_*=0.
- Accept at edge k. oDATA_BUSY is high from just after edge k. Steps occur at edges k+1..k+N, and oDATA_VALID rises after edge k+N. Default latency is 12 cycles.
- If iDATA_BUSY=0 at edge k+N+1, valid falls and busy drops after that edge. The next accept can happen at edge k+N+2, so peak throughput is one result per N+2 cycles.
- Each extra cycle of iDATA_BUSY extends DONE by one cycle. There is no loss or duplication of results.
- Applying iRESET_SYNC at any cycle makes valid and busy low after the next edge.

## Test plan
- 1.5×1.5: FRACT_A=FRACT_B=24'hC00000, EXP_A=EXP_B=8'd127, signs 0/0 → after 12 cycles oDATA_FRACT=48'h900000000000, oDATA_EXP=10'h07F, oDATA_SIGN=0.
- Max significands with minimal exponents: 24'hFFFFFF × 24'hFFFFFF, EXP_A=EXP_B=1, signs 1/0 → oDATA_FRACT=48'hFFFFFE000001, oDATA_EXP=10'h383 (−125), oDATA_SIGN=1.
- Backpressure: hold iDATA_BUSY=1 for 5 cycles after valid rises → valid and all outputs stay stable for 6 cycles. Busy toward upstream stays high. A second operand held valid throughout is accepted exactly once, 2 cycles after iDATA_BUSY falls.
- Abort: pulse iRESET_SYNC during step 6 → next cycle valid=0, busy=0, all outputs zero. A fresh operand then completes correctly.
- Flags and zero: FRACT_A=0, EXCEPT_FRACT_A0=1, other flags a mix of 0 and 1 → product 48'h0 after the full N cycles, and the flags appear unchanged at the outputs.
- Parameter sweep: for BITS_PER_CYCLE=1 and 4, run 1000 random operand pairs against a reference model → latency 24 and 6 cycles respectively, bit-exact products.

Source files
------------

// File: rtl/mul_float_fract_iterative.sv
// Iterative significand multiplier: shift-add over 24/BITS_PER_CYCLE steps,
// producing sign, pre-normalisation exponent and the exact 48-bit product.
//   state | meaning
//   IDLE  | ready to accept an operand pair
//   CALC  | shift-add steps in progress
//   DONE  | result valid, held until downstream is not busy
`timescale 1ns/1ps
module mul_float_fract_iterative #(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic        iDATA_VALID,
  output logic        oDATA_BUSY,
  input  logic        iDATA_SIGN_A,
  input  logic        iDATA_SIGN_B,
  input  logic [7:0]  iDATA_EXP_A,
  input  logic [7:0]  iDATA_EXP_B,
  input  logic [23:0] iDATA_FRACT_A,
  input  logic [23:0] iDATA_FRACT_B,
  input  logic        iDATA_EXCEPT_EXP_A0,
  input  logic        iDATA_EXCEPT_EXP_B0,
  input  logic        iDATA_EXCEPT_EXP_A1,
  input  logic        iDATA_EXCEPT_EXP_B1,
  input  logic        iDATA_EXCEPT_FRACT_A0,
  input  logic        iDATA_EXCEPT_FRACT_B0,
  output logic        oDATA_VALID,
  input  logic        iDATA_BUSY,
  output logic        oDATA_SIGN,
  output logic [9:0]  oDATA_EXP,
  output logic [47:0] oDATA_FRACT,
  output logic        oDATA_EXCEPT_EXP_A0,
  output logic        oDATA_EXCEPT_EXP_B0,
  output logic        oDATA_EXCEPT_EXP_A1,
  output logic        oDATA_EXCEPT_EXP_B1,
  output logic        oDATA_EXCEPT_FRACT_A0,
  output logic        oDATA_EXCEPT_FRACT_B0
);
  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = 24 / BPC;
  localparam int CW  = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   step_cnt;
  logic [23:0]     mcand;
  // upper half accumulates partial products, lower half holds unretired multiplier bits
  logic [47:0]     prod;
  logic [BPC-1:0]  digit;
  logic [23+BPC:0] pp;
  logic [23+BPC:0] sum_hi;
  logic [47:0]     prod_next;
  logic            accept, step, last_step;

  assign accept    = (state == IDLE) && iDATA_VALID;
  assign step      = (state == CALC);
  assign last_step = step && (step_cnt == LAST_STEP);

  assign digit     = prod[BPC-1:0];
  assign pp        = {{BPC{1'b0}}, mcand} * {{24{1'b0}}, digit};
  assign sum_hi    = {{BPC{1'b0}}, prod[47:24]} + pp;
  assign prod_next = {sum_hi, prod[23:BPC]};

  assign oDATA_BUSY  = (state != IDLE);
  assign oDATA_VALID = (state == DONE);

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state <= IDLE;
    end else if (iRESET_SYNC) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (iDATA_VALID) state_next = CALC;
      CALC:    if (step_cnt == LAST_STEP) state_next = DONE;
      DONE:    if (!iDATA_BUSY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      step_cnt              <= '0;
      mcand                 <= '0;
      prod                  <= '0;
      oDATA_SIGN            <= 1'b0;
      oDATA_EXP             <= '0;
      oDATA_FRACT           <= '0;
      oDATA_EXCEPT_EXP_A0   <= 1'b0;
      oDATA_EXCEPT_EXP_B0   <= 1'b0;
      oDATA_EXCEPT_EXP_A1   <= 1'b0;
      oDATA_EXCEPT_EXP_B1   <= 1'b0;
      oDATA_EXCEPT_FRACT_A0 <= 1'b0;
      oDATA_EXCEPT_FRACT_B0 <= 1'b0;
    end else if (iRESET_SYNC) begin
      step_cnt              <= '0;
      mcand                 <= '0;
      prod                  <= '0;
      oDATA_SIGN            <= 1'b0;
      oDATA_EXP             <= '0;
      oDATA_FRACT           <= '0;
      oDATA_EXCEPT_EXP_A0   <= 1'b0;
      oDATA_EXCEPT_EXP_B0   <= 1'b0;
      oDATA_EXCEPT_EXP_A1   <= 1'b0;
      oDATA_EXCEPT_EXP_B1   <= 1'b0;
      oDATA_EXCEPT_FRACT_A0 <= 1'b0;
      oDATA_EXCEPT_FRACT_B0 <= 1'b0;
    end else if (accept) begin
      step_cnt              <= '0;
      mcand                 <= iDATA_FRACT_A;
      prod                  <= {24'h000000, iDATA_FRACT_B};
      oDATA_SIGN            <= iDATA_SIGN_A ^ iDATA_SIGN_B;
      // wraps modulo 2^10, giving the two's complement unbiased-sum exponent
      oDATA_EXP             <= {2'b00, iDATA_EXP_A} + {2'b00, iDATA_EXP_B} - 10'd127;
      oDATA_EXCEPT_EXP_A0   <= iDATA_EXCEPT_EXP_A0;
      oDATA_EXCEPT_EXP_B0   <= iDATA_EXCEPT_EXP_B0;
      oDATA_EXCEPT_EXP_A1   <= iDATA_EXCEPT_EXP_A1;
      oDATA_EXCEPT_EXP_B1   <= iDATA_EXCEPT_EXP_B1;
      oDATA_EXCEPT_FRACT_A0 <= iDATA_EXCEPT_FRACT_A0;
      oDATA_EXCEPT_FRACT_B0 <= iDATA_EXCEPT_FRACT_B0;
    end else if (step) begin
      step_cnt <= step_cnt + 1'b1;
      prod     <= prod_next;
      if (last_step) begin
        oDATA_FRACT <= prod_next;
      end
    end
  end
endmodule
